// File: rtl/sum_acc_pkg.sv
// Shared types and default sizing for the sum accumulator.
package sum_acc_pkg;
  localparam int SUM_W_DEF = 5;
  localparam int N_DEF     = 8;
  localparam int ACC_W_DEF = 8;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;
endpackage

// File: rtl/sum_accumulator_sat_add.sv
// Saturating unsigned adder: clamps to all-ones and flags the clamp.
module sat_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_acc,
  input  logic [W-1:0] i_samp,
  output logic [W-1:0] o_sum,
  output logic         o_sat
);
  logic [W:0] w_full;

  assign w_full = {1'b0, i_acc} + {1'b0, i_samp};
  assign o_sat  = w_full[W];
  assign o_sum  = o_sat ? '1 : w_full[W-1:0];
endmodule

// File: rtl/sum_accumulator.sv
// Accumulates blocks of up to N upstream sums, then holds the total
// until the consumer takes it. Assumes ACC_W >= SUM_W.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEF,
  parameter int N     = N_DEF,
  parameter int ACC_W = ACC_W_DEF,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  state_e           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic [ACC_W-1:0] w_samp, w_sum;
  logic             w_sat, w_accept, w_last, w_release;

  assign w_samp    = ACC_W'(in_sum);
  assign w_accept  = in_valid && (r_state == ACC);
  assign w_last    = (r_cnt == CNT_W'(N - 1));
  assign w_release = (r_state == DONE) && out_ready;

  sat_add #(.W(ACC_W)) u_sat_add (
    .i_acc  (r_acc),
    .i_samp (w_samp),
    .o_sum  (w_sum),
    .o_sat  (w_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACC;
    else        r_state <= w_state_nxt;
  end

  // An empty block never closes: flush needs a prior or same-cycle sample.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACC: begin
        if (w_accept && (w_last || flush))  w_state_nxt = DONE;
        else if (flush && (r_cnt != '0))    w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) w_state_nxt = ACC;
      end
      default: w_state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_release) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + CNT_W'(1);
      r_ovf <= r_ovf | w_sat;
    end
  end

  // Accumulator state is frozen in DONE, so it drives the result directly.
  assign in_ready  = (r_state == ACC);
  assign out_valid = (r_state == DONE);
  assign out_acc   = r_acc;
  assign out_count = r_cnt;
  assign out_ovf   = r_ovf;
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default build plus a 7-bit-accumulator
// build sharing one stimulus stream, checked against a block-level scoreboard.
module tb_sum_accumulator;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic [4:0] in_sum = '0;

  logic       in_ready, out_valid, out_ovf;
  logic [7:0] out_acc;
  logic [3:0] out_count;
  logic       in_ready7, out_valid7, out_ovf7;
  logic [6:0] out_acc7;
  logic [3:0] out_count7;

  always #5 clk = ~clk;

  sum_accumulator u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );

  sum_accumulator #(.ACC_W(7)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready7),
    .in_sum(in_sum), .flush(flush), .out_valid(out_valid7), .out_ready(out_ready),
    .out_acc(out_acc7), .out_count(out_count7), .out_ovf(out_ovf7)
  );

  typedef struct {
    int acc8;
    bit ovf8;
    int acc7;
    bit ovf7;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  bit m_done;
  int m_cnt, m_acc8, m_acc7;
  bit m_ovf8, m_ovf7;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_done = 1'b0;
    m_cnt  = 0;
    m_acc8 = 0;
    m_acc7 = 0;
    m_ovf8 = 1'b0;
    m_ovf7 = 1'b0;
  endtask

  task automatic close_block();
    exp_t e;
    e.acc8 = m_acc8; e.ovf8 = m_ovf8;
    e.acc7 = m_acc7; e.ovf7 = m_ovf7;
    e.cnt  = m_cnt;
    q.push_back(e);
    m_done = 1'b1;
  endtask

  task automatic sample_checks();
    chk("in_ready",   in_ready,   !m_done);
    chk("out_valid",  out_valid,  m_done);
    chk("in_ready7",  in_ready7,  !m_done);
    chk("out_valid7", out_valid7, m_done);
    if (m_done) begin
      if (q.size() == 0) chk("queue_has_entry", 0, 1);
      else begin
        chk("out_acc",    out_acc,    q[0].acc8);
        chk("out_ovf",    out_ovf,    q[0].ovf8);
        chk("out_count",  out_count,  q[0].cnt);
        chk("out_acc7",   out_acc7,   q[0].acc7);
        chk("out_ovf7",   out_ovf7,   q[0].ovf7);
        chk("out_count7", out_count7, q[0].cnt);
        if (out_ready) void'(q.pop_front());
      end
    end
  endtask

  // One clock: drive, check at negedge, advance the model, land at posedge+1.
  task automatic step(bit v, int s, bit f, bit ordy);
    int t8, t7;
    in_valid = v; in_sum = s[4:0]; flush = f; out_ready = ordy;
    @(negedge clk);
    sample_checks();
    if (!m_done) begin
      if (v) begin
        t8 = m_acc8 + s;
        t7 = m_acc7 + s;
        if (t8 > 255) begin t8 = 255; m_ovf8 = 1'b1; end
        if (t7 > 127) begin t7 = 127; m_ovf7 = 1'b1; end
        m_acc8 = t8;
        m_acc7 = t7;
        m_cnt++;
        if (m_cnt == N || f) close_block();
      end else if (f && m_cnt > 0) close_block();
    end else if (ordy) model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int cycles);
    in_valid = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_acc",   out_acc,   0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf",   out_ovf,   0);
    chk("rst_out_acc7",  out_acc7,  0);
    model_clear();
    q.delete();
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int a;
    int guard;
    model_clear();
    #2;
    do_reset(2);

    // Eight samples of 30 back to back; 7-bit build saturates.
    for (int i = 0; i < 8; i++) step(1, 30, 0, 1);
    chk("blk_full_acc",   out_acc,   240);
    chk("blk_full_count", out_count, 8);
    chk("blk_full_ovf",   out_ovf,   0);
    chk("sat_acc7",       out_acc7,  127);
    chk("sat_ovf7",       out_ovf7,  1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);

    // Early close with a same-cycle sample, then empty flush.
    step(1, 5, 0, 1);
    step(1, 6, 0, 1);
    step(1, 7, 0, 1);
    step(1, 2, 1, 1);
    chk("flush_acc",   out_acc,   20);
    chk("flush_count", out_count, 4);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    step(1, 3, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);

    // Back-pressure: result held while in_valid stays high, flush ignored.
    for (int i = 0; i < 8; i++) step(1, 4, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 31, 1, 0);
    chk("hold_acc", out_acc, 32);
    step(1, 31, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 10, 0, 1);
    chk("after_hold_acc", out_acc, 80);
    step(0, 0, 0, 1);

    // Reset mid-block discards the partial total.
    for (int i = 0; i < 4; i++) step(1, 9, 0, 1);
    do_reset(2);
    step(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 1);
    chk("post_rst_acc",   out_acc,   8);
    chk("post_rst_count", out_count, 8);
    step(0, 0, 0, 1);

    // Random gaps; each in_sum is a+b from an upstream adder model.
    guard = 0;
    while (!m_done && guard < 200) begin
      a = $urandom_range(0, 17);
      step(bit'($urandom_range(0, 1)), a + (17 - a), 0, 1);
      guard++;
    end
    if (!m_done) chk("rand_block_timeout", guard, 0);
    chk("rand_acc", out_acc, 136);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
